// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA frame buffer.
// Pixel type, colour constants and the fill-engine state encoding.
package vga_pkg;

  localparam int PIX_W_DEF = 24;

  typedef logic [PIX_W_DEF-1:0] pixel_t;

  localparam pixel_t BG_DEF = 24'h000000;
  localparam pixel_t BLACK  = 24'h000000;
  localparam pixel_t WHITE  = 24'hFFFFFF;

  typedef enum logic {
    IDLE,
    FILL
  } fb_state_e;

endpackage

// File: rtl/fb_ram.sv
// Simple dual-port pixel store: one write port, one registered read port.
// A same-address read and write in one cycle returns the old word.
module fb_ram #(
  parameter int DW    = 24,
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/vga_framebuf.sv
// Writable, optionally double-buffered VGA frame buffer with a
// clear-screen fill engine, pixel-replication scaling and vsync page flip.
module vga_framebuf
  import vga_pkg::*;
#(
  parameter int H_RES       = 640,
  parameter int V_RES       = 480,
  parameter int H_BITS      = 10,
  parameter int V_BITS      = 10,
  parameter int PIX_W       = 24,
  parameter int SCALE_SHIFT = 0,
  parameter int DOUBLE_BUF  = 1,
  parameter logic [PIX_W-1:0] BG_COLOR = BG_DEF
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              rd_en,
  input  logic [H_BITS-1:0] h_addr,
  input  logic [V_BITS-1:0] v_addr,
  output logic [PIX_W-1:0]  rd_data,
  output logic              rd_valid,
  input  logic              frame_start,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [H_BITS-1:0] wr_x,
  input  logic [V_BITS-1:0] wr_y,
  input  logic [PIX_W-1:0]  wr_data,
  input  logic              fill_start,
  input  logic [PIX_W-1:0]  fill_color,
  input  logic              flip_req,
  output logic              busy,
  output logic              flip_pending,
  output logic              front_page,
  output logic              wr_oob
);

  localparam int W     = H_RES >> SCALE_SHIFT;
  localparam int H     = V_RES >> SCALE_SHIFT;
  localparam int DEPTH = W * H;
  localparam int TOTAL = (DOUBLE_BUF != 0) ? 2 * DEPTH : DEPTH;
  localparam int AW    = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam int CW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fb_state_e        state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PIX_W-1:0] fcol_q, fcol_d;
  logic             front_q, front_d;
  logic             pend_q, pend_d;
  logic             oob_q, oob_d;
  logic             rd_en_q;
  logic             rd_in_q, rd_in_d;

  logic             back_pg;
  logic             wr_acc;
  logic             wr_in;
  logic             ram_we;
  logic [AW-1:0]    ram_waddr;
  logic [AW-1:0]    ram_raddr;
  logic [PIX_W-1:0] ram_wdata;
  logic [PIX_W-1:0] ram_rdata;

  function automatic logic [AW-1:0] lin(
    input logic        pg,
    input logic [31:0] off
  );
    return AW'((pg ? 32'(DEPTH) : 32'd0) + off);
  endfunction

  // Read side: scale display coords down into stored space.
  assign rd_in_d = (32'(h_addr) < H_RES) && (32'(v_addr) < V_RES);
  assign ram_raddr = lin(front_q,
    32'(v_addr >> SCALE_SHIFT) * 32'(W) + 32'(h_addr >> SCALE_SHIFT));

  assign busy     = (state_q == FILL);
  assign back_pg  = (DOUBLE_BUF != 0) && !front_q;
  assign wr_ready = resetn && (state_q == IDLE) && !fill_start;
  assign wr_acc   = wr_valid && wr_ready;
  assign wr_in    = (32'(wr_x) < W) && (32'(wr_y) < H);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    fcol_d    = fcol_q;
    oob_d     = oob_q;
    ram_we    = 1'b0;
    ram_wdata = wr_data;
    ram_waddr = lin(back_pg, 32'(wr_y) * 32'(W) + 32'(wr_x));
    unique case (state_q)
      IDLE: begin
        if (fill_start) begin
          state_d = FILL;
          cnt_d   = '0;
          fcol_d  = fill_color;
        end else if (wr_acc) begin
          if (wr_in) ram_we = 1'b1;
          else       oob_d  = 1'b1;
        end
      end
      FILL: begin
        ram_we    = 1'b1;
        ram_wdata = fcol_q;
        ram_waddr = lin(back_pg, 32'(cnt_q));
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == CW'(DEPTH - 1)) state_d = IDLE;
      end
    endcase
  end

  // Pages only swap while the fill engine is quiet.
  always_comb begin
    front_d = front_q;
    pend_d  = pend_q;
    if (DOUBLE_BUF != 0) begin
      if (frame_start && (pend_q || flip_req) && !busy) begin
        front_d = !front_q;
        pend_d  = 1'b0;
      end else if (flip_req) begin
        pend_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      fcol_q  <= '0;
      front_q <= 1'b0;
      pend_q  <= 1'b0;
      oob_q   <= 1'b0;
      rd_en_q <= 1'b0;
      rd_in_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fcol_q  <= fcol_d;
      front_q <= front_d;
      pend_q  <= pend_d;
      oob_q   <= oob_d;
      rd_en_q <= rd_en;
      rd_in_q <= rd_in_d;
    end
  end

  fb_ram #(
    .DW    (PIX_W),
    .DEPTH (TOTAL),
    .AW    (AW)
  ) u_ram (
    .clk_i   (clock),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .raddr_i (ram_raddr),
    .rdata_o (ram_rdata)
  );

  assign rd_data = !rd_en_q ? '0 :
                   !rd_in_q ? BG_COLOR : ram_rdata;

  assign rd_valid     = rd_en_q;
  assign flip_pending = pend_q;
  assign front_page   = front_q;
  assign wr_oob       = oob_q;

endmodule

// File: tb/tb_vga_framebuf.sv
// Directed bench for vga_framebuf on an 8x4 screen in three configs:
// single buffer, double buffer, and single buffer with 2x scaling.
module tb_vga_framebuf;

  localparam int N = 3;
  localparam logic [23:0] BG = 24'h0A0B0C;

  logic        clock = 1'b0;
  logic        resetn;
  logic        rd_en        [N];
  logic [3:0]  h_addr       [N];
  logic [3:0]  v_addr       [N];
  logic [23:0] rd_data      [N];
  logic        rd_valid     [N];
  logic        frame_start  [N];
  logic        wr_valid     [N];
  logic        wr_ready     [N];
  logic [3:0]  wr_x         [N];
  logic [3:0]  wr_y         [N];
  logic [23:0] wr_data      [N];
  logic        fill_start   [N];
  logic [23:0] fill_color   [N];
  logic        flip_req     [N];
  logic        busy         [N];
  logic        flip_pending [N];
  logic        front_page   [N];
  logic        wr_oob       [N];

  always #5 clock = ~clock;

  for (genvar g = 0; g < N; g++) begin : g_dut
    vga_framebuf #(
      .H_RES       (8),
      .V_RES       (4),
      .H_BITS      (4),
      .V_BITS      (4),
      .PIX_W       (24),
      .SCALE_SHIFT ((g == 2) ? 1 : 0),
      .DOUBLE_BUF  ((g == 1) ? 1 : 0),
      .BG_COLOR    (BG)
    ) u_dut (
      .clock        (clock),
      .resetn       (resetn),
      .rd_en        (rd_en[g]),
      .h_addr       (h_addr[g]),
      .v_addr       (v_addr[g]),
      .rd_data      (rd_data[g]),
      .rd_valid     (rd_valid[g]),
      .frame_start  (frame_start[g]),
      .wr_valid     (wr_valid[g]),
      .wr_ready     (wr_ready[g]),
      .wr_x         (wr_x[g]),
      .wr_y         (wr_y[g]),
      .wr_data      (wr_data[g]),
      .fill_start   (fill_start[g]),
      .fill_color   (fill_color[g]),
      .flip_req     (flip_req[g]),
      .busy         (busy[g]),
      .flip_pending (flip_pending[g]),
      .front_page   (front_page[g]),
      .wr_oob       (wr_oob[g])
    );
  end

  typedef struct {
    int          d;
    logic        en;
    int          h;
    int          v;
    logic [23:0] dat;
    logic        vld;
    string       nm;
  } rv_t;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic wr(input int d, input int x, input int y,
                    input logic [23:0] px);
    wr_valid[d] = 1'b1;
    wr_x[d]     = x[3:0];
    wr_y[d]     = y[3:0];
    wr_data[d]  = px;
    tick();
    wr_valid[d] = 1'b0;
  endtask

  task automatic apply(input rv_t r);
    rd_en[r.d]  = r.en;
    h_addr[r.d] = r.h[3:0];
    v_addr[r.d] = r.v[3:0];
    tick();
    chk({r.nm, "_data"}, 32'(rd_data[r.d]), 32'(r.dat));
    chk({r.nm, "_valid"}, 32'(rd_valid[r.d]), 32'(r.vld));
    rd_en[r.d] = 1'b0;
  endtask

  task automatic rdchk(input int d, input int h, input int v,
                       input logic [23:0] exp, input string nm);
    rv_t r;
    r = '{d: d, en: 1'b1, h: h, v: v, dat: exp, vld: 1'b1, nm: nm};
    apply(r);
  endtask

  task automatic pulse_flip(input int d, input logic req,
                            input logic fs);
    flip_req[d]    = req;
    frame_start[d] = fs;
    tick();
    flip_req[d]    = 1'b0;
    frame_start[d] = 1'b0;
  endtask

  task automatic start_fill(input int d, input logic [23:0] c);
    fill_start[d] = 1'b1;
    fill_color[d] = c;
    tick();
    fill_start[d] = 1'b0;
  endtask

  // Counts negedges with busy high; stray fill_start at n==5 must be ignored.
  task automatic count_busy(input int d, output int n);
    n = 0;
    while (busy[d] === 1'b1 && n < 200) begin
      if (n == 0) chk("fill_wr_ready", 32'(wr_ready[d]), 32'd0);
      fill_start[d] = (n == 5);
      fill_color[d] = 24'hFF00FF;
      n++;
      tick();
    end
    fill_start[d] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rv_t tab[$];
    int  n;

    resetn = 1'b0;
    for (int i = 0; i < N; i++) begin
      rd_en[i] = 0; h_addr[i] = 0; v_addr[i] = 0;
      frame_start[i] = 0; wr_valid[i] = 0; wr_x[i] = 0;
      wr_y[i] = 0; wr_data[i] = 0; fill_start[i] = 0;
      fill_color[i] = 0; flip_req[i] = 0;
    end
    repeat (3) tick();

    chk("rst_rd_data", 32'(rd_data[1]), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid[1]), 32'd0);
    chk("rst_busy", 32'(busy[1]), 32'd0);
    chk("rst_pending", 32'(flip_pending[1]), 32'd0);
    chk("rst_front", 32'(front_page[1]), 32'd0);
    chk("rst_oob", 32'(wr_oob[0]), 32'd0);
    chk("rst_wr_ready", 32'(wr_ready[0]), 32'd0);
    resetn = 1'b1;
    tick();
    chk("idle_wr_ready", 32'(wr_ready[0]), 32'd1);

    wr(0, 3, 2, 24'hFF0000);
    wr(0, 0, 1, 24'h222222);
    wr(0, 5, 1, 24'h444444);
    chk("oob_clear", 32'(wr_oob[0]), 32'd0);
    wr(0, 8, 0, 24'hABCDEF);
    chk("oob_set", 32'(wr_oob[0]), 32'd1);
    wr(0, 6, 3, 24'h5A5A5A);
    chk("oob_sticky", 32'(wr_oob[0]), 32'd1);

    // Same-cycle write and read of one address returns the old word.
    wr_valid[0] = 1'b1; wr_x[0] = 4'd5; wr_y[0] = 4'd1;
    wr_data[0] = 24'h333333;
    rd_en[0] = 1'b1; h_addr[0] = 4'd5; v_addr[0] = 4'd1;
    tick();
    wr_valid[0] = 1'b0; rd_en[0] = 1'b0;
    chk("collide_old", 32'(rd_data[0]), 32'h444444);

    wr(2, 1, 1, 24'h123456);
    wr(2, 2, 1, 24'hABCDEF);

    tab.push_back('{0, 1'b1, 3, 2, 24'hFF0000, 1'b1, "t1_px"});
    tab.push_back('{0, 1'b1, 9, 0, BG, 1'b1, "h_oob"});
    tab.push_back('{0, 1'b1, 0, 4, BG, 1'b1, "v_oob"});
    tab.push_back('{0, 1'b0, 3, 2, 24'h0, 1'b0, "rd_off"});
    tab.push_back('{0, 1'b0, 9, 0, 24'h0, 1'b0, "rd_off_oob"});
    tab.push_back('{0, 1'b1, 0, 1, 24'h222222, 1'b1, "oob_nowrap"});
    tab.push_back('{0, 1'b1, 5, 1, 24'h333333, 1'b1, "collide_new"});
    tab.push_back('{0, 1'b1, 6, 3, 24'h5A5A5A, 1'b1, "corner"});
    tab.push_back('{2, 1'b1, 2, 2, 24'h123456, 1'b1, "sc22"});
    tab.push_back('{2, 1'b1, 3, 2, 24'h123456, 1'b1, "sc32"});
    tab.push_back('{2, 1'b1, 2, 3, 24'h123456, 1'b1, "sc23"});
    tab.push_back('{2, 1'b1, 3, 3, 24'h123456, 1'b1, "sc33"});
    tab.push_back('{2, 1'b1, 4, 2, 24'hABCDEF, 1'b1, "sc42"});
    tab.push_back('{2, 1'b1, 5, 3, 24'hABCDEF, 1'b1, "sc53"});
    tab.push_back('{2, 1'b1, 8, 2, BG, 1'b1, "sc_oob"});
    foreach (tab[i]) apply(tab[i]);

    // Single-buffer fill; flip is ignored in this config.
    fill_start[0] = 1'b1;
    fill_color[0] = 24'h00FF00;
    #1 chk("fs_blocks_wr", 32'(wr_ready[0]), 32'd0);
    tick();
    fill_start[0] = 1'b0;
    count_busy(0, n);
    chk("fill_cycles", 32'(n), 32'd32);
    pulse_flip(0, 1'b1, 1'b1);
    chk("sb_front", 32'(front_page[0]), 32'd0);
    chk("sb_pending", 32'(flip_pending[0]), 32'd0);
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 8; x++)
        rdchk(0, x, y, 24'h00FF00, "fill_px");

    // Double buffer: immediate flip, then a flip deferred by a fill.
    wr(1, 1, 1, 24'h777777);
    pulse_flip(1, 1'b1, 1'b1);
    chk("flip_now", 32'(front_page[1]), 32'd1);
    chk("flip_now_pend", 32'(flip_pending[1]), 32'd0);
    start_fill(1, 24'h555555);
    chk("db_busy", 32'(busy[1]), 32'd1);
    pulse_flip(1, 1'b1, 1'b0);
    chk("req_pend", 32'(flip_pending[1]), 32'd1);
    pulse_flip(1, 1'b0, 1'b1);
    chk("busy_noflip", 32'(front_page[1]), 32'd1);
    chk("busy_pend", 32'(flip_pending[1]), 32'd1);
    n = 0;
    while (busy[1] === 1'b1 && n < 200) begin n++; tick(); end
    chk("db_fill_done", 32'(busy[1]), 32'd0);
    wr(1, 1, 1, 24'h0000FF);
    rdchk(1, 1, 1, 24'h777777, "front_old");
    pulse_flip(1, 1'b0, 1'b1);
    chk("late_flip", 32'(front_page[1]), 32'd0);
    chk("late_pend", 32'(flip_pending[1]), 32'd0);
    rdchk(1, 1, 1, 24'h0000FF, "flipped_px");
    rdchk(1, 7, 3, 24'h555555, "flipped_fill");

    // Reset in the middle of a fill, then refill from the start.
    pulse_flip(1, 1'b1, 1'b1);
    chk("pre_rst_front", 32'(front_page[1]), 32'd1);
    start_fill(1, 24'h999999);
    repeat (3) tick();
    pulse_flip(1, 1'b1, 1'b0);
    chk("pre_rst_busy", 32'(busy[1]), 32'd1);
    chk("pre_rst_pend", 32'(flip_pending[1]), 32'd1);
    resetn = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy[1]), 32'd0);
    chk("mid_rst_front", 32'(front_page[1]), 32'd0);
    chk("mid_rst_pend", 32'(flip_pending[1]), 32'd0);
    chk("mid_rst_oob", 32'(wr_oob[0]), 32'd0);
    tick();
    resetn = 1'b1;
    tick();
    start_fill(1, 24'h888888);
    count_busy(1, n);
    chk("refill_cycles", 32'(n), 32'd32);
    pulse_flip(1, 1'b1, 1'b1);
    chk("refill_front", 32'(front_page[1]), 32'd1);
    rdchk(1, 0, 0, 24'h888888, "refill_first");
    rdchk(1, 3, 1, 24'h888888, "refill_mid");
    rdchk(1, 7, 3, 24'h888888, "refill_last");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
